// File: rtl/jtag_axi_pkg.sv
// Shared AXI4 bundle types, stall-injector modes and channel indices.
// No logic: types, constants and the LFSR step function only.
// Backpressure: n/a.
package jtag_axi_pkg;

  typedef enum logic [1:0] {
    INJ_PASS  = 2'd0,
    INJ_FIXED = 2'd1,
    INJ_RAND  = 2'd2,
    INJ_BLOCK = 2'd3
  } inj_mode_t;

  localparam int CH_AW   = 0;
  localparam int CH_W    = 1;
  localparam int CH_B    = 2;
  localparam int CH_AR   = 3;
  localparam int CH_R    = 4;
  localparam int INJ_NCH = 5;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   aw_id;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_vld;
    logic [AXI_DATA_W-1:0] w_dat;
    logic [AXI_STRB_W-1:0] w_strb;
    logic                  w_last;
    logic                  w_vld;
    logic                  b_rdy;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_vld;
    logic                  r_rdy;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  aw_rdy;
    logic                  w_rdy;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_vld;
    logic                  ar_rdy;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_dat;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_vld;
  } s_axi_miso_t;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/axi_stall_gate.sv
// Single-channel valid/ready gate with programmable stall and stall-cycle counter.
// Latency: 0 cycles when open; D cycles from src_valid to open for a delayed beat.
// Backpressure: once opened for a beat the gate stays open until the handshake.
module axi_stall_gate
  import jtag_axi_pkg::*;
#(
  parameter int DLY_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_axi,
  input  logic             ares_axi,
  input  logic             src_valid,
  input  logic             dst_ready,
  input  inj_mode_t        mode,
  input  logic [DLY_W-1:0] delay,
  input  logic [DLY_W-1:0] rnd,
  input  logic             stall_clr,
  output logic             open,
  output logic             blocked,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BLOCK = 2'd2
  } gate_st_t;

  gate_st_t         state;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] beat_dly;
  logic             idle_open;
  logic             open_raw;
  logic             hs;

  // Delay for a beat starting now, and the resulting gate state; reset forces it shut
  always_comb begin
    beat_dly = '0;
    case (mode)
      INJ_FIXED: beat_dly = delay;
      INJ_RAND:  beat_dly = rnd & delay;
      default:   beat_dly = '0;
    endcase
    idle_open = (mode != INJ_BLOCK) && (beat_dly == '0);
    case (state)
      ST_IDLE: open_raw = idle_open;
      ST_WAIT: open_raw = (cnt == '0);
      default: open_raw = 1'b0;
    endcase
    open = open_raw & ares_axi;
    hs   = src_valid & dst_ready & open;
  end

  // Per-beat stall FSM; a beat presented open but not accepted parks in WAIT with
  // cnt=0 so a later mode/LFSR change can never withdraw it
  always_ff @(posedge clk_axi or negedge ares_axi) begin
    if (!ares_axi) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      blocked <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (src_valid) begin
            if (mode == INJ_BLOCK) begin
              state   <= ST_BLOCK;
              blocked <= 1'b1;
            end else if (beat_dly != '0) begin
              cnt   <= beat_dly - 1'b1;
              state <= ST_WAIT;
            end else if (!dst_ready) begin
              cnt   <= '0;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (hs) begin
            state <= ST_IDLE;
          end
        end
        ST_BLOCK: begin
          if (mode != INJ_BLOCK) begin
            state   <= ST_IDLE;
            blocked <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          blocked <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where the source offers a beat but the gate is shut
  always_ff @(posedge clk_axi or negedge ares_axi) begin
    if (!ares_axi) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (src_valid && !open && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi_stall_injector.sv
// AXI4 handshake gate between master and slave injecting per-channel stalls.
// Latency: payload combinational; valid delayed 0..D cycles per beat by mode.
// Backpressure: ready forwarded only while a channel gate is open; never withdraws valid.
module axi_stall_injector
  import jtag_axi_pkg::*;
#(
  parameter int          DLY_W     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                            clk_axi,
  input  logic                            ares_axi,
  input  s_axi_mosi_t                     m_mosi_i,
  output s_axi_miso_t                     m_miso_o,
  output s_axi_mosi_t                     s_mosi_o,
  input  s_axi_miso_t                     s_miso_i,
  input  logic [INJ_NCH-1:0][1:0]         cfg_mode_i,
  input  logic [INJ_NCH-1:0][DLY_W-1:0]   cfg_delay_i,
  input  logic                            stall_clr_i,
  output logic [INJ_NCH-1:0][CNT_W-1:0]   stall_cnt_o,
  output logic [INJ_NCH-1:0]              blocked_o
);

  logic [15:0]        lfsr_q;
  logic [INJ_NCH-1:0] src_vld;
  logic [INJ_NCH-1:0] dst_rdy;
  logic [INJ_NCH-1:0] gate_open;

  // Free-running LFSR shared by every channel in RAND mode
  always_ff @(posedge clk_axi or negedge ares_axi) begin
    if (!ares_axi) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr16_next(lfsr_q);
    end
  end

  // Pick each channel's source valid and destination ready out of the bundles
  always_comb begin
    src_vld          = '0;
    dst_rdy          = '0;
    src_vld[CH_AW]   = m_mosi_i.aw_vld;
    dst_rdy[CH_AW]   = s_miso_i.aw_rdy;
    src_vld[CH_W]    = m_mosi_i.w_vld;
    dst_rdy[CH_W]    = s_miso_i.w_rdy;
    src_vld[CH_B]    = s_miso_i.b_vld;
    dst_rdy[CH_B]    = m_mosi_i.b_rdy;
    src_vld[CH_AR]   = m_mosi_i.ar_vld;
    dst_rdy[CH_AR]   = s_miso_i.ar_rdy;
    src_vld[CH_R]    = s_miso_i.r_vld;
    dst_rdy[CH_R]    = m_mosi_i.r_rdy;
  end

  for (genvar ch = 0; ch < INJ_NCH; ch++) begin : g_gate
    axi_stall_gate #(
      .DLY_W (DLY_W),
      .CNT_W (CNT_W)
    ) u_gate (
      .clk_axi   (clk_axi),
      .ares_axi  (ares_axi),
      .src_valid (src_vld[ch]),
      .dst_ready (dst_rdy[ch]),
      .mode      (inj_mode_t'(cfg_mode_i[ch])),
      .delay     (cfg_delay_i[ch]),
      .rnd       (lfsr_q[DLY_W-1:0]),
      .stall_clr (stall_clr_i),
      .open      (gate_open[ch]),
      .blocked   (blocked_o[ch]),
      .stall_cnt (stall_cnt_o[ch])
    );
  end

  // Payload passes untouched; only the valid/ready pairs are overridden by the gates
  always_comb begin
    s_mosi_o        = m_mosi_i;
    s_mosi_o.aw_vld = src_vld[CH_AW] & gate_open[CH_AW];
    s_mosi_o.w_vld  = src_vld[CH_W]  & gate_open[CH_W];
    s_mosi_o.ar_vld = src_vld[CH_AR] & gate_open[CH_AR];
    s_mosi_o.b_rdy  = dst_rdy[CH_B]  & gate_open[CH_B];
    s_mosi_o.r_rdy  = dst_rdy[CH_R]  & gate_open[CH_R];
    m_miso_o        = s_miso_i;
    m_miso_o.aw_rdy = dst_rdy[CH_AW] & gate_open[CH_AW];
    m_miso_o.w_rdy  = dst_rdy[CH_W]  & gate_open[CH_W];
    m_miso_o.ar_rdy = dst_rdy[CH_AR] & gate_open[CH_AR];
    m_miso_o.b_vld  = src_vld[CH_B]  & gate_open[CH_B];
    m_miso_o.r_vld  = src_vld[CH_R]  & gate_open[CH_R];
  end

endmodule

// File: tb/tb_axi_stall_injector.sv
// Directed bench: bench drives the master side, a small memory slave answers.
// Outputs are sampled on the falling edge; inputs change 1 time unit after rising edge.
// Every wait is cycle-bounded; an expired bound shows up as a failed comparison.
module tb_axi_stall_injector;
  import jtag_axi_pkg::*;

  localparam int DLY_W = 8;
  localparam int CNT_W = 16;

  logic                          clk_axi = 1'b0;
  logic                          ares_axi;
  s_axi_mosi_t                   m_mosi;
  s_axi_miso_t                   m_miso;
  s_axi_mosi_t                   s_mosi;
  s_axi_miso_t                   s_miso;
  logic [INJ_NCH-1:0][1:0]       cfg_mode;
  logic [INJ_NCH-1:0][DLY_W-1:0] cfg_delay;
  logic                          stall_clr;
  logic [INJ_NCH-1:0][CNT_W-1:0] stall_cnt;
  logic [INJ_NCH-1:0]            blocked;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  int rand_lat [2][32];
  int rand_sum [2];
  int rand_cnt [2];
  int rand_bad [2];

  always #5 clk_axi = ~clk_axi;

  axi_stall_injector #(.DLY_W(DLY_W), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .clk_axi     (clk_axi),
    .ares_axi    (ares_axi),
    .m_mosi_i    (m_mosi),
    .m_miso_o    (m_miso),
    .s_mosi_o    (s_mosi),
    .s_miso_i    (s_miso),
    .cfg_mode_i  (cfg_mode),
    .cfg_delay_i (cfg_delay),
    .stall_clr_i (stall_clr),
    .stall_cnt_o (stall_cnt),
    .blocked_o   (blocked)
  );

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  // Memory slave: always ready on AW/W/AR, one read outstanding, holds B/R until accepted
  initial begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_lst, b_pend, r_pend;
    logic [31:0] aw_a, ar_a, w_d, wr_ptr, rd_ptr;
    logic [3:0] aw_i, ar_i, b_id_q, r_id_q;
    s_miso = '0; b_pend = 0; r_pend = 0; wr_ptr = 0; rd_ptr = 0; b_id_q = 0; r_id_q = 0;
    forever begin
      @(negedge clk_axi);
      aw_hs = s_mosi.aw_vld & s_miso.aw_rdy; aw_a = s_mosi.aw_addr; aw_i = s_mosi.aw_id;
      w_hs  = s_mosi.w_vld & s_miso.w_rdy;   w_d = s_mosi.w_dat;    w_lst = s_mosi.w_last;
      b_hs  = s_miso.b_vld & s_mosi.b_rdy;
      ar_hs = s_mosi.ar_vld & s_miso.ar_rdy; ar_a = s_mosi.ar_addr; ar_i = s_mosi.ar_id;
      r_hs  = s_miso.r_vld & s_mosi.r_rdy;
      @(posedge clk_axi); #1;
      if (!ares_axi) begin
        b_pend = 0; r_pend = 0;
      end else begin
        if (aw_hs) begin wr_ptr = aw_a; b_id_q = aw_i; end
        if (w_hs) begin mem[wr_ptr] = w_d; wr_ptr = wr_ptr + 4; end
        if (b_hs) b_pend = 0;
        if (w_hs && w_lst) b_pend = 1;
        if (r_hs) r_pend = 0;
        if (ar_hs) begin r_pend = 1; rd_ptr = ar_a; r_id_q = ar_i; end
      end
      s_miso.aw_rdy = 1; s_miso.w_rdy = 1; s_miso.ar_rdy = 1;
      s_miso.b_vld = b_pend; s_miso.b_id = b_id_q; s_miso.b_resp = 2'b00;
      s_miso.r_vld = r_pend; s_miso.r_id = r_id_q; s_miso.r_resp = 2'b00;
      s_miso.r_dat = rd_mem(rd_ptr); s_miso.r_last = 1'b1;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_axi); #1;
  endtask

  task automatic do_reset();
    ares_axi = 1'b0; m_mosi = '0; stall_clr = 1'b0;
    repeat (2) tick();
    ares_axi = 1'b1;
    tick();
  endtask

  task automatic clear_counters();
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
  endtask

  // lat: cycles before the slave sees valid; rdy_cyc: cycles master saw ready
  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                         output int lat, output int rdy_cyc, output bit ok);
    bit seen;
    m_mosi.aw_addr = addr; m_mosi.aw_len = len; m_mosi.aw_size = 3'd2;
    m_mosi.aw_burst = 2'd1; m_mosi.aw_id = 4'd1; m_mosi.aw_vld = 1'b1;
    lat = 0; rdy_cyc = 0; ok = 0; seen = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_axi);
      if (m_miso.aw_rdy) rdy_cyc++;
      if (s_mosi.aw_vld) seen = 1; else if (!seen) lat++;
      if (m_miso.aw_rdy && m_mosi.aw_vld) ok = 1;
      tick();
    end
    m_mosi.aw_vld = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d0, input int nb, output int lmin,
                        output int lmax, output bit last_ok, output bit ok);
    bit done, seen;
    int lat;
    lmin = 1000; lmax = 0; last_ok = 1; ok = 1;
    for (int b = 0; b < nb; b++) begin
      done = 0; seen = 0; lat = 0;
      m_mosi.w_dat = d0 + b; m_mosi.w_strb = '1; m_mosi.w_last = (b == nb - 1);
      m_mosi.w_vld = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
        @(negedge clk_axi);
        if (s_mosi.w_vld) seen = 1; else if (!seen) lat++;
        if (m_miso.w_rdy && m_mosi.w_vld) begin
          done = 1;
          if (s_mosi.w_last !== (b == nb - 1)) last_ok = 0;
        end
        tick();
      end
      if (!done) ok = 0;
      if (lat < lmin) lmin = lat;
      if (lat > lmax) lmax = lat;
    end
    m_mosi.w_vld = 1'b0; m_mosi.w_last = 1'b0;
  endtask

  task automatic wait_b(input int budget, output bit ok);
    ok = 0;
    m_mosi.b_rdy = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_axi);
      if (m_miso.b_vld && m_mosi.b_rdy) ok = 1;
      tick();
    end
    m_mosi.b_rdy = 1'b0;
  endtask

  // Single-beat read; rready toggles in a fixed pattern; wd flags a withdrawn rvalid
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output int lat, output bit ok, output bit wd);
    bit ar_ok, seen, prev_v, prev_r;
    int k;
    m_mosi.ar_addr = addr; m_mosi.ar_len = 8'd0; m_mosi.ar_size = 3'd2;
    m_mosi.ar_burst = 2'd1; m_mosi.ar_id = 4'd2; m_mosi.ar_vld = 1'b1;
    ar_ok = 0; ok = 0; wd = 0; lat = 0; seen = 0; prev_v = 0; prev_r = 0; k = 0; data = '0;
    for (int i = 0; i < 100 && !ar_ok; i++) begin
      @(negedge clk_axi);
      if (m_miso.ar_rdy && m_mosi.ar_vld) ar_ok = 1;
      tick();
    end
    m_mosi.ar_vld = 1'b0;
    for (int i = 0; i < 100 && ar_ok && !ok; i++) begin
      m_mosi.r_rdy = (k % 3 != 1); k++;
      @(negedge clk_axi);
      if (prev_v && !prev_r && !m_miso.r_vld) wd = 1;
      if (m_miso.r_vld) seen = 1; else if (!seen && s_miso.r_vld) lat++;
      prev_v = m_miso.r_vld; prev_r = m_mosi.r_rdy;
      if (m_miso.r_vld && m_mosi.r_rdy) begin ok = 1; data = m_miso.r_dat; end
      tick();
    end
    m_mosi.r_rdy = 1'b0;
  endtask

  task automatic test_reset();
    ares_axi = 1'b0;
    m_mosi.aw_addr = 32'h1234_5678; m_mosi.aw_vld = 1'b1; m_mosi.w_vld = 1'b1;
    tick(); tick();
    checks++; if (s_mosi.aw_vld !== 1'b0) begin errors++; $display("FAIL rst_s_awvalid: got %b expected 0", s_mosi.aw_vld); end
    checks++; if (m_miso.aw_rdy !== 1'b0) begin errors++; $display("FAIL rst_m_awready: got %b expected 0", m_miso.aw_rdy); end
    checks++; if (s_mosi.w_vld !== 1'b0) begin errors++; $display("FAIL rst_s_wvalid: got %b expected 0", s_mosi.w_vld); end
    checks++; if (s_mosi.aw_addr !== 32'h1234_5678) begin errors++; $display("FAIL rst_payload: got %h expected 12345678", s_mosi.aw_addr); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rst_stall_cnt: got %h expected 0", stall_cnt); end
    checks++; if (blocked !== '0) begin errors++; $display("FAIL rst_blocked: got %b expected 0", blocked); end
    m_mosi = '0;
    ares_axi = 1'b1;
    tick(); tick();
  endtask

  task automatic test_pass();
    int lat, rc, lmin, lmax; bit ok, lok, wd; logic [31:0] d;
    send_aw(32'h100, 8'd0, lat, rc, ok);
    checks++; if (!ok || lat !== 0) begin errors++; $display("FAIL pass_aw_lat: got %0d ok=%b expected 0", lat, ok); end
    send_w(32'hDEAD_BEEF, 1, lmin, lmax, lok, ok);
    checks++; if (!ok || lmax !== 0 || !lok) begin errors++; $display("FAIL pass_w_lat: got %0d ok=%b last=%b expected 0", lmax, ok, lok); end
    wait_b(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pass_b: got no response expected bvalid"); end
    do_read(32'h100, d, lat, ok, wd);
    checks++; if (!ok || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pass_rdata: got %h ok=%b expected deadbeef", d, ok); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL pass_r_lat: got %0d expected 0", lat); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL pass_stall_cnt: got %h expected 0", stall_cnt); end
  endtask

  task automatic test_aw_fixed();
    int lat, rc, lmin, lmax; bit ok, lok;
    clear_counters();
    cfg_mode[CH_AW] = INJ_FIXED; cfg_delay[CH_AW] = 8'd5;
    tick();
    send_aw(32'h200, 8'd0, lat, rc, ok);
    checks++; if (!ok || lat !== 5) begin errors++; $display("FAIL aw_fixed_lat: got %0d ok=%b expected 5", lat, ok); end
    checks++; if (rc !== 1) begin errors++; $display("FAIL aw_fixed_ready_cycles: got %0d expected 1", rc); end
    checks++; if (stall_cnt[CH_AW] !== 16'd5) begin errors++; $display("FAIL aw_fixed_stall_cnt: got %0d expected 5", stall_cnt[CH_AW]); end
    send_w(32'h0BAD_F00D, 1, lmin, lmax, lok, ok);
    wait_b(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL aw_fixed_b: got no response expected bvalid"); end
    cfg_mode[CH_AW] = INJ_PASS; cfg_delay[CH_AW] = 8'd0;
  endtask

  task automatic test_w_fixed();
    int lat, rc, lmin, lmax; bit ok, lok, wd; logic [31:0] d;
    clear_counters();
    checks++; if (stall_cnt[CH_AW] !== 16'd0) begin errors++; $display("FAIL stall_clr: got %0d expected 0", stall_cnt[CH_AW]); end
    cfg_mode[CH_W] = INJ_FIXED; cfg_delay[CH_W] = 8'd2;
    send_aw(32'h300, 8'd3, lat, rc, ok);
    send_w(32'h1000, 4, lmin, lmax, lok, ok);
    checks++; if (!ok || lmin !== 2 || lmax !== 2) begin errors++; $display("FAIL w_fixed_lat: got min %0d max %0d ok=%b expected 2", lmin, lmax, ok); end
    checks++; if (!lok) begin errors++; $display("FAIL w_fixed_wlast: got misplaced wlast expected beat 4 only"); end
    wait_b(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL w_fixed_b: got no response expected bvalid"); end
    checks++; if (stall_cnt[CH_W] !== 16'd8) begin errors++; $display("FAIL w_fixed_stall_cnt: got %0d expected 8", stall_cnt[CH_W]); end
    cfg_mode[CH_W] = INJ_PASS; cfg_delay[CH_W] = 8'd0;
    do_read(32'h30C, d, lat, ok, wd);
    checks++; if (!ok || d !== 32'h1003) begin errors++; $display("FAIL w_fixed_beat4_data: got %h expected 1003", d); end
  endtask

  task automatic test_b_block();
    int lat, rc, lmin, lmax, nb; bit ok, lok;
    clear_counters();
    cfg_mode[CH_B] = INJ_BLOCK;
    send_aw(32'h400, 8'd0, lat, rc, ok);
    send_w(32'hCAFE_0001, 1, lmin, lmax, lok, ok);
    m_mosi.b_rdy = 1'b1; nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_axi);
      if (m_miso.b_vld) nb++;
      tick();
    end
    checks++; if (nb !== 0) begin errors++; $display("FAIL b_block_bvalid: got %0d cycles expected 0", nb); end
    checks++; if (blocked[CH_B] !== 1'b1) begin errors++; $display("FAIL b_block_flag: got %b expected 1", blocked[CH_B]); end
    checks++; if (stall_cnt[CH_B] == 16'd0) begin errors++; $display("FAIL b_block_stall_cnt: got 0 expected nonzero"); end
    cfg_mode[CH_B] = INJ_PASS;
    wait_b(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b_release: got no response expected bvalid"); end
    checks++; if (blocked[CH_B] !== 1'b0) begin errors++; $display("FAIL b_release_flag: got %b expected 0", blocked[CH_B]); end
  endtask

  task automatic rand_run(input int p);
    int lat; bit ok, wd; logic [31:0] d, a;
    cfg_mode = '0; cfg_delay = '0;
    cfg_mode[CH_R] = INJ_RAND; cfg_delay[CH_R] = 8'h07;
    do_reset();
    rand_sum[p] = 0; rand_bad[p] = 0;
    for (int i = 0; i < 32; i++) begin
      a = 32'h1000 + 32'(4 * i);
      do_read(a, d, lat, ok, wd);
      rand_lat[p][i] = lat;
      rand_sum[p] += lat;
      if (!ok || wd || lat > 7 || d !== ~a) rand_bad[p]++;
    end
    rand_cnt[p] = int'(stall_cnt[CH_R]);
  endtask

  task automatic test_r_rand();
    int diff;
    rand_run(0);
    rand_run(1);
    checks++; if (rand_bad[0] !== 0) begin errors++; $display("FAIL r_rand_beats: got %0d bad reads expected 0", rand_bad[0]); end
    checks++; if (rand_bad[1] !== 0) begin errors++; $display("FAIL r_rand_rerun_beats: got %0d bad reads expected 0", rand_bad[1]); end
    checks++; if (rand_cnt[0] !== rand_sum[0]) begin errors++; $display("FAIL r_rand_stall_cnt: got %0d expected %0d", rand_cnt[0], rand_sum[0]); end
    checks++; if (rand_sum[0] == 0) begin errors++; $display("FAIL r_rand_nonzero: got total delay 0 expected nonzero"); end
    diff = 0;
    for (int i = 0; i < 32; i++) if (rand_lat[0][i] != rand_lat[1][i]) diff++;
    checks++; if (diff !== 0) begin errors++; $display("FAIL r_rand_repeat: got %0d differing delays expected 0", diff); end
    cfg_mode[CH_R] = INJ_PASS; cfg_delay[CH_R] = 8'd0;
  endtask

  task automatic test_reset_in_wait();
    int lat; bit ok, wd; logic [31:0] d;
    cfg_mode[CH_AR] = INJ_FIXED; cfg_delay[CH_AR] = 8'd5;
    tick();
    m_mosi.ar_addr = 32'h100; m_mosi.ar_id = 4'd3; m_mosi.ar_vld = 1'b1;
    tick(); tick();
    checks++; if (stall_cnt[CH_AR] !== 16'd2) begin errors++; $display("FAIL ar_wait_stall_cnt: got %0d expected 2", stall_cnt[CH_AR]); end
    m_mosi.aw_vld = 1'b1;
    ares_axi = 1'b0;
    #1;
    checks++; if (s_mosi.ar_vld !== 1'b0 || m_miso.ar_rdy !== 1'b0) begin errors++; $display("FAIL arst_ar: got arvalid %b arready %b expected 0 0", s_mosi.ar_vld, m_miso.ar_rdy); end
    checks++; if (s_mosi.aw_vld !== 1'b0 || m_miso.aw_rdy !== 1'b0) begin errors++; $display("FAIL arst_aw_pass: got awvalid %b awready %b expected 0 0", s_mosi.aw_vld, m_miso.aw_rdy); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL arst_stall_cnt: got %h expected 0", stall_cnt); end
    m_mosi = '0;
    tick(); tick();
    ares_axi = 1'b1;
    cfg_mode[CH_AR] = INJ_PASS; cfg_delay[CH_AR] = 8'd0;
    tick();
    do_read(32'h100, d, lat, ok, wd);
    checks++; if (!ok || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL arst_read: got %h ok=%b expected deadbeef", d, ok); end
  endtask

  initial begin
    ares_axi = 1'b0; m_mosi = '0; stall_clr = 1'b0;
    cfg_mode = '0; cfg_delay = '0;
    test_reset();
    test_pass();
    test_aw_fixed();
    test_w_fixed();
    test_b_block();
    test_r_rand();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_stall_injector.md
Name: axi_stall_injector

Overview:
- Verification-side AXI4 handshake gate inserted between an AXI master (e.g. jtag_axi_wrapper) and its slave model.
- Generalises hard per-channel ready/valid forcing into per-channel programmable stall modes: pass-through, fixed delay, pseudo-random delay, and permanent block for timeout injection.
- Every stall is AXI-legal: once a gated VALID is presented downstream, it is never withdrawn before its handshake.
- Counts injected stall cycles per channel.

Parameters:
- DLY_W, 8, width of per-channel delay value/mask.
- CNT_W, 16, width of per-channel saturating stall counter.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be non-zero.

Ports:
- clk_axi  in  1  AXI clock.
- ares_axi  in  1  reset; asynchronous, active-low.
- m_mosi_i  in  s_axi_mosi_t  request bundle from master.
- m_miso_o  out  s_axi_miso_t  response bundle to master.
- s_mosi_o  out  s_axi_mosi_t  request bundle to slave.
- s_miso_i  in  s_axi_miso_t  response bundle from slave.
- cfg_mode_i  in  5x2  per-channel mode, index order AW, W, B, AR, R.
- cfg_delay_i  in  5xDLY_W  fixed delay (FIXED) or mask (RAND).
- stall_clr_i  in  1  synchronous clear of all stall counters.
- stall_cnt_o  out  5xCNT_W  saturating stall-cycle counters.
- blocked_o  out  5  channel currently in BLOCK state.

Behaviour:
- Payload fields (id, addr, len, size, burst, data, strb, last, resp, user, etc.) pass combinationally, unmodified, in both directions.
- Only valid/ready pairs are gated.
  - Source side: AW, W, AR = master; B, R = slave.
  - For each channel: dst_valid = src_valid & open; src_ready = dst_ready & open.
- Per-channel FSM states: IDLE, WAIT, BLOCK. Handshake hs = src_valid & dst_ready & open.
- IDLE, mode PASS, or FIXED with delay 0: open=1 combinationally. hs keeps the FSM in IDLE.
- IDLE, src_valid=1, mode FIXED (D>0) or RAND: load D and compute cnt<=D-1; go to WAIT; open=0 this cycle.
  - RAND: D = lfsr[DLY_W-1:0] & cfg_delay_i. If D=0, behave as PASS for this beat.
- WAIT: open = (cnt==0). While cnt!=0, cnt decrements. At cnt==0, hold open until hs, then return to IDLE.
- Resulting latency: dst_valid first rises exactly D cycles after src_valid first rises.
- IDLE, src_valid=1, mode BLOCK: go to BLOCK; open=0; blocked_o=1.
- BLOCK: leave to IDLE when mode != BLOCK. The next beat is treated fresh in IDLE.
- Mode/delay are sampled only in IDLE. Changes during WAIT do not affect the beat in flight, and an open gate is never closed before hs.
- Upstream dropping src_valid during WAIT is ignored; cnt still runs.
- W bursts: each beat is gated independently; wlast passes through.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle, resets to LFSR_SEED.
- stall_cnt[ch] increments when src_valid & !open. It saturates at all-ones. stall_clr_i has priority over increment.
- Reset (async assert): all FSMs to IDLE, cnt=0, stall_cnt_o=0, blocked_o=0, LFSR=LFSR_SEED.
  - All gated dst_valid and src_ready outputs are forced 0 while ares_axi=0, including channels in PASS mode.
  - Payload remains pass-through.
- Deassertion is synchronous to clk_axi externally; no internal synchroniser.

Decomposition:
- jtag_axi_pkg:
  - typedef enum logic [1:0] inj_mode_t {INJ_PASS=0, INJ_FIXED=1, INJ_RAND=2, INJ_BLOCK=3}.
  - Channel index constants CH_AW=0, CH_W=1, CH_B=2, CH_AR=3, CH_R=4, and INJ_NCH=5.
- Sub-module axi_stall_gate:
  - Contents: one FSM, delay counter, and stall counter.
  - Ports: clk_axi, ares_axi, src_valid, dst_ready, mode, delay, rnd, stall_clr, open, blocked, stall_cnt.
  - Instantiated 5 times; the shared LFSR and struct unpacking live in the top level.

Test Plan:
- All channels PASS, write then read at addr 0x100 data 0xDEADBEEF -> zero added latency, readback 0xDEADBEEF, all stall_cnt=0.
- AW FIXED delay 5, single write -> s awvalid rises exactly 5 cycles after m awvalid; stall_cnt[AW]=5; awready to master only on the handshake cycle.
- W FIXED delay 2, 4-beat burst (awlen=3) -> each beat delayed 2 cycles, wlast intact on beat 4, stall_cnt[W]=8.
- B BLOCK during write -> bvalid never reaches master, blocked_o[2]=1; switch B to PASS -> B response delivered, blocked_o[2]=0, master completes.
- R RAND mask 0x07, 32 reads -> every delay is in 0..7, no dst_valid withdrawn before rready, all data correct; identical delay sequence on rerun with same LFSR_SEED.
- Assert ares_axi low in AR WAIT with cnt=3 -> arvalid/arready to slave and master immediately 0, counters 0; after release, a new read completes normally.
